// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencer for a loadable up counter. On an accepted start it captures the
// start value, terminal value and run count. Each run loads the counter and
// then enables counting until the counter output equals the terminal value.
// This repeats for the programmed number of runs.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      sequence request, sampled only while idle
//   abort      cancels the active sequence (ignored while idle)
//   hold       pauses counting while high
//   start_val  value loaded at the start of every run
//   end_val    terminal count value
//   reps       number of runs (0 is rejected with an err pulse)
//   cnt_value  count output of the controlled counter
//   cnt_load   counter load strobe
//   cnt_data   counter load data
//   cnt_en     counter count enable
//   busy       high while a sequence is active
//   run_idx    runs completed in the current or last sequence
//   run_done   one-cycle pulse per completed run
//   done       one-cycle pulse when all runs are complete
//   aborted    one-cycle pulse after an abort
//   err        one-cycle pulse after a start with reps == 0
// ----------------------------------------------------------------------------
module count_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_en,
    output logic             busy,
    output logic [REP_W-1:0] run_idx,
    output logic             run_done,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sv_q, sv_d;
    logic [WIDTH-1:0] ev_q, ev_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] run_idx_q, run_idx_d;
    logic             run_done_q, run_done_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;

    logic             terminal;
    logic [REP_W-1:0] run_idx_inc;

    // Terminal detection looks only at the counter output, so a held
    // counter that already sits on the end value still completes its run.
    assign terminal    = (state_q == RUN) && (cnt_value == ev_q);
    assign run_idx_inc = run_idx_q + REP_W'(1);

    // Counter-facing controls decode straight from the state so the counter
    // sees them in the same cycle. Abort suppresses both strobes immediately.
    always_comb begin
        cnt_data = sv_q;
        cnt_load = (state_q == LOAD) && !abort;
        cnt_en   = (state_q == RUN) && !abort && !terminal && !hold;
        busy     = (state_q != IDLE);
    end

    assign run_idx  = run_idx_q;
    assign run_done = run_done_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign err      = err_q;

    // Next-state logic. Status pulses default low and are raised only on
    // the cycle whose edge completes the triggering event.
    always_comb begin
        state_d    = state_q;
        sv_d       = sv_q;
        ev_d       = ev_q;
        reps_d     = reps_q;
        run_idx_d  = run_idx_q;
        run_done_d = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        sv_d      = start_val;
                        ev_d      = end_val;
                        reps_d    = reps;
                        run_idx_d = '0;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort wins over a simultaneous terminal: the run is not
                // counted as completed.
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (terminal) begin
                    run_idx_d  = run_idx_inc;
                    run_done_d = 1'b1;
                    if (run_idx_inc == reps_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and shadow registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sv_q       <= '0;
            ev_q       <= '0;
            reps_q     <= '0;
            run_idx_q  <= '0;
            run_done_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sv_q       <= sv_d;
            ev_q       <= ev_d;
            reps_q     <= reps_d;
            run_idx_q  <= run_idx_d;
            run_done_q <= run_done_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl
// ----------------------------------------------------------------------------
// Bench for count_seq_ctrl. A simple loadable counter closes the loop on
// cnt_value. A sequence-level model predicts every output on every falling
// edge. It works from the remaining number of count cycles in the current
// run rather than from the counter value. Directed sequences pin the model
// with hand-computed totals, then a randomized phase exercises the rest.
// ----------------------------------------------------------------------------
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] startVal = '0;
    logic [3:0] endVal = '0;
    logic [3:0] reps = '0;
    logic [3:0] cntValue;
    logic       cntLoad;
    logic [3:0] cntData;
    logic       cntEn;
    logic       busy;
    logic [3:0] runIdx;
    logic       runDone;
    logic       done;
    logic       aborted;
    logic       err;

    int testsRun = 0;
    int testsFailed = 0;

    // Running totals of output activity, sampled on falling edges.
    int tLoad = 0, tEn = 0, tBusy = 0, tRunDone = 0, tDone = 0, tAborted = 0, tErr = 0;

    // Sequence-level model state, describing the situation after the last edge.
    bit mBusy = 0, mInLoad = 0;
    int mSv = 0, mEv = 0, mReps = 0, mRunIdx = 0, mLeft = 0;
    bit mRunDone = 0, mDone = 0, mAborted = 0, mErr = 0;

    // Snapshot totals of the most recent directed sequence.
    int dLoad, dEn, dBusy, dRunDone, dDone, dAborted;

    count_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .hold(hold),
        .start_val(startVal),
        .end_val(endVal),
        .reps(reps),
        .cnt_value(cntValue),
        .cnt_load(cntLoad),
        .cnt_data(cntData),
        .cnt_en(cntEn),
        .busy(busy),
        .run_idx(runIdx),
        .run_done(runDone),
        .done(done),
        .aborted(aborted),
        .err(err)
    );

    always #5 clk = ~clk;

    // The controlled counter: load has priority over enable, wraps mod 16.
    always @(posedge clk or posedge rst) begin
        if (rst)          cntValue <= '0;
        else if (cntLoad) cntValue <= cntData;
        else if (cntEn)   cntValue <= cntValue + 4'd1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle prediction and comparison, followed by the model step.
    task automatic modelCycle(input int cyc);
        logic [14:0] expVec, actVec;
        bit eLoad, eEn;
        bit nRunDone, nDone, nAborted, nErr;
        eLoad = 0;
        eEn = 0;
        if (rst) begin
            expVec = '0;
        end else begin
            if (mBusy && mInLoad) eLoad = !abort;
            if (mBusy && !mInLoad) eEn = !abort && (mLeft != 0) && !hold;
            expVec = {eLoad, 4'(mSv), eEn, mBusy, 4'(mRunIdx), mRunDone, mDone, mAborted, mErr};
        end
        actVec = {cntLoad, cntData, cntEn, busy, runIdx, runDone, done, aborted, err};
        testsRun++;
        if (actVec !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL cycle%0d outputs {load,data,en,busy,idx,rd,done,ab,err}: got %b, expected %b",
                     cyc, actVec, expVec);
        end
        tLoad += int'(cntLoad);
        tEn += int'(cntEn);
        tBusy += int'(busy);
        tRunDone += int'(runDone);
        tDone += int'(done);
        tAborted += int'(aborted);
        tErr += int'(err);

        nRunDone = 0;
        nDone = 0;
        nAborted = 0;
        nErr = 0;
        if (rst) begin
            mBusy = 0; mInLoad = 0; mSv = 0; mEv = 0; mReps = 0; mRunIdx = 0; mLeft = 0;
        end else if (!mBusy) begin
            if (start) begin
                if (reps != 0) begin
                    mSv = int'(startVal);
                    mEv = int'(endVal);
                    mReps = int'(reps);
                    mRunIdx = 0;
                    mBusy = 1;
                    mInLoad = 1;
                end else begin
                    nErr = 1;
                end
            end
        end else if (abort) begin
            mBusy = 0;
            nAborted = 1;
        end else if (mInLoad) begin
            mInLoad = 0;
            mLeft = (mEv - mSv + 16) % 16;
        end else if (mLeft == 0) begin
            mRunIdx++;
            nRunDone = 1;
            if (mRunIdx == mReps) begin
                nDone = 1;
                mBusy = 0;
            end else begin
                mInLoad = 1;
            end
        end else if (!hold) begin
            mLeft--;
        end
        mRunDone = nRunDone;
        mDone = nDone;
        mAborted = nAborted;
        mErr = nErr;
    endtask

    // Runs one sequence to completion. Hold is raised for holdN cycles once the
    // counter reaches holdAt; abort is raised when the counter reaches abortAt.
    task automatic applyStimulus(input logic [3:0] sv, input logic [3:0] ev, input logic [3:0] rp,
                                 input int holdN, input int holdAt, input int abortAt);
        int holdLeft, c;
        int sLoad, sEn, sBusy, sRunDone, sDone, sAborted;
        holdLeft = holdN;
        sLoad = tLoad; sEn = tEn; sBusy = tBusy;
        sRunDone = tRunDone; sDone = tDone; sAborted = tAborted;
        start = 1'b1;
        startVal = sv;
        endVal = ev;
        reps = rp;
        @(posedge clk); #1;
        start = 1'b0;
        startVal = ~sv;
        endVal = ~ev;
        reps = 4'd15;
        c = 0;
        while (busy && c < 300) begin
            hold = 1'b0;
            abort = 1'b0;
            if (!cntLoad && holdLeft > 0 && int'(cntValue) == holdAt) begin
                hold = 1'b1;
                holdLeft--;
            end
            if (!cntLoad && abortAt >= 0 && int'(cntValue) == abortAt) abort = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        hold = 1'b0;
        abort = 1'b0;
        checkOutput("sequenceFinishedInBudget", int'(busy), 0);
        @(negedge clk); #1;
        dLoad = tLoad - sLoad;
        dEn = tEn - sEn;
        dBusy = tBusy - sBusy;
        dRunDone = tRunDone - sRunDone;
        dDone = tDone - sDone;
        dAborted = tAborted - sAborted;
        @(posedge clk); #1;
    endtask

    initial begin
        fork
            begin
                int cyc;
                cyc = 0;
                forever begin
                    @(negedge clk);
                    modelCycle(cyc);
                    cyc++;
                end
            end
        join_none

        @(posedge clk); #1;
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetRunIdx", int'(runIdx), 0);
        checkOutput("resetCntData", int'(cntData), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] sequence sv=3 ev=7 reps=1");
        applyStimulus(4'd3, 4'd7, 4'd1, 0, 0, -1);
        checkOutput("t1Loads", dLoad, 1);
        checkOutput("t1EnCycles", dEn, 4);
        checkOutput("t1BusyCycles", dBusy, 6);
        checkOutput("t1RunDone", dRunDone, 1);
        checkOutput("t1Done", dDone, 1);
        checkOutput("t1RunIdx", int'(runIdx), 1);

        $display("[TB] sequence sv=2 ev=4 reps=3");
        applyStimulus(4'd2, 4'd4, 4'd3, 0, 0, -1);
        checkOutput("t2Loads", dLoad, 3);
        checkOutput("t2EnCycles", dEn, 6);
        checkOutput("t2BusyCycles", dBusy, 12);
        checkOutput("t2RunDone", dRunDone, 3);
        checkOutput("t2Done", dDone, 1);
        checkOutput("t2RunIdx", int'(runIdx), 3);

        $display("[TB] wrapping sequence sv=14 ev=1 reps=1");
        applyStimulus(4'd14, 4'd1, 4'd1, 0, 0, -1);
        checkOutput("t3EnCycles", dEn, 3);
        checkOutput("t3BusyCycles", dBusy, 5);
        checkOutput("t3Done", dDone, 1);

        $display("[TB] hold for 2 cycles at count 2, sv=0 ev=5");
        applyStimulus(4'd0, 4'd5, 4'd1, 2, 2, -1);
        checkOutput("t4EnCycles", dEn, 5);
        checkOutput("t4BusyCycles", dBusy, 9);
        checkOutput("t4Done", dDone, 1);

        $display("[TB] abort at count 5, reps=2");
        applyStimulus(4'd0, 4'd9, 4'd2, 0, 0, 5);
        checkOutput("t5Aborted", dAborted, 1);
        checkOutput("t5RunDone", dRunDone, 0);
        checkOutput("t5Done", dDone, 0);
        checkOutput("t5RunIdx", int'(runIdx), 0);

        $display("[TB] start with reps=0");
        start = 1'b1;
        reps = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("t5ErrPulse", int'(err), 1);
        checkOutput("t5ErrBusy", int'(busy), 0);
        @(posedge clk); #1;
        checkOutput("t5ErrSingleCycle", int'(err), 0);

        $display("[TB] reset mid-run, then sv=ev=9");
        start = 1'b1;
        startVal = 4'd0;
        endVal = 4'd15;
        reps = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("t6RunningBeforeReset", int'(cntEn), 1);
        rst = 1'b1;
        #1;
        checkOutput("t6OutputsZeroInReset",
                    int'({cntLoad, cntData, cntEn, busy, runIdx, runDone, done, aborted, err}), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(4'd9, 4'd9, 4'd1, 0, 0, -1);
        checkOutput("t6Loads", dLoad, 1);
        checkOutput("t6EnCycles", dEn, 0);
        checkOutput("t6BusyCycles", dBusy, 2);
        checkOutput("t6Done", dDone, 1);

        $display("[TB] randomized phase");
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            reps = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
            startVal = 4'($urandom_range(0, 15));
            endVal = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 4) == 0);
            abort = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        hold = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
